spectrum_peak_scan: RTL and testbench
=====================================

Name: spectrum_peak_scan

Overview:
- Consumes the per-bin magnitude-squared stream produced after the FFT core: one 32-bit |X|² value per bin, framed by SOP/EOP, with the FFT block exponent.
- Per frame, over a programmable inclusive bin band, it finds the peak bin (value and index), accumulates total band energy and counts completed frames.
- Results and sticky status are exposed on the Nios slave bus. The AGC firmware reads one register set instead of scanning the 256-word spectrum RAM.

Parameters:
- FRAME_LEN, 256, bins per frame; power of two, ≥2
- BIN_W, 8, bin index width; equals log2(FRAME_LEN)
- ACC_W, 48, energy accumulator width; range 33..64

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  bin beat valid
- in_sop  in  1  first bin of frame; qualified by in_valid
- in_eop  in  1  last bin of frame; qualified by in_valid
- in_data  in  32  unsigned |X|² of the current bin
- in_exp  in  6  FFT block exponent; signed
- cs  in  1  bus chip select
- wr  in  1  bus write strobe
- rd  in  1  bus read strobe
- addr  in  4  bus word address
- wrdata  in  32  bus write data
- rddata  out  32  registered bus read data
- irq  out  1  equals the done flag

Behaviour:
- Reset: every register clears. This covers rddata, irq, all result registers, all flags, enable, band (lo=0, hi=0), frame counter, bin counter and accumulators. The state machine goes to IDLE. A reset mid-frame discards the frame.
- Register map, word addresses:
  - 0 CTRL: bit0 = enable, read/write.
  - 1 BAND: lo = [BIN_W-1:0], hi = [16+BIN_W-1:16], read/write.
  - 2 STATUS: bit0 done, bit1 len_err, bit2 ovr. Reads return the flags; writing 1 to a bit clears it.
  - 3 PEAK_VAL: [31:0], read-only.
  - 4 PEAK_INFO: idx = [BIN_W-1:0], exp = [21:16], read-only.
  - 5 ENERGY_LO: [31:0], read-only.
  - 6 ENERGY_HI: energy[ACC_W-1:32], zero-extended, read-only.
  - 7 FRAME_CNT: [15:0], read-only; wraps 0xFFFF→0.
  - Any other address reads 0.
- Bus access:
  - wr&cs takes priority over rd&cs in the same cycle.
  - On rd&cs, rddata updates on the next edge (1-cycle latency) and otherwise holds.
  - Writes to read-only addresses are ignored.
- IDLE:
  - Waits for in_valid & in_sop & enable.
  - Valid beats without sop are ignored.
  - On the sop beat: bin counter = 0; peak = that beat (if in band) or 0/idx 0; energy = that beat (if in band) or 0. Go to ACCUM.
- ACCUM, per valid beat:
  - bin = counter+1.
  - If lo ≤ bin ≤ hi: energy += in_data, saturating at all-ones; if in_data > peak (strictly greater), peak/idx take this beat. Ties therefore keep the earliest bin.
  - Beats with in_valid=0 are stalls: no counter change.
- Frame close, valid eop beat with bin = FRAME_LEN-1 (that beat included):
  - On the next edge, PEAK_VAL, PEAK_INFO (exp taken from in_exp on the eop beat) and ENERGY update atomically.
  - FRAME_CNT increments. Go to IDLE.
  - Set done. If done was already 1, also set ovr.
- Length errors, all setting len_err:
  - eop with bin ≠ FRAME_LEN-1: discard frame, no result update, go to IDLE.
  - Reaching bin = FRAME_LEN-1 without eop: discard, go to IDLE.
  - sop in ACCUM: restart the frame with this beat as bin 0.
  - sop&eop on one beat: discard, go to IDLE.
- Empty band: lo > hi (or bins outside the frame) gives peak 0, idx 0, energy 0. The frame still closes normally.
- Clearing enable mid-frame aborts the frame with no flags set; the next frame must start with a new sop.
- Writing BAND mid-frame takes effect on the next beat; firmware changes it only when idle.
- Flag set and W1C clear in the same cycle: set wins.
- irq = done, registered; it falls one cycle after the W1C write.

Test Plan:
- enable=1, band 0..255, 256 beats with data=bin, back-to-back → PEAK_VAL=255, idx=255, ENERGY=32640, FRAME_CNT=1, done=1, irq=1.
- Same frame with random in_valid gaps, band 10..20, data=1000 at bins 12 and 15, else 5 → peak 1000 at idx 12, ENERGY=2000+9×5=2045.
- All beats data=0xFFFFFFFF, ACC_W=33, band 0..255 → ENERGY saturates to 0x1_FFFF_FFFF (HI=1, LO=0xFFFFFFFF).
- eop at bin 100 → len_err=1, done=0, results unchanged; the next good frame closes normally with FRAME_CNT=1.
- Two good frames without clearing done → ovr=1. W1C write of 0x7 in the same cycle as the third frame's eop → done=1, ovr=1 remain set.
- Assert rst at bin 50, then feed a full frame → all registers read 0 until enable is rewritten. After enable, the frame completes with FRAME_CNT=1. Also cover lo=200, hi=100 → peak 0, energy 0, done=1.

Source files
------------

// File: rtl/spectrum_peak_scan.sv
// ============================================================================
// spectrum_peak_scan : per-frame band peak / energy scanner with Nios registers
// Rev 1.0
// ============================================================================
`default_nettype none

module spectrum_peak_scan #(
  parameter int FRAME_LEN = 256,
  parameter int BIN_W     = 8,
  parameter int ACC_W     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_exp,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [31:0] wrdata,
  output logic [31:0] rddata,
  output logic        irq
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [BIN_W-1:0] c_last_bin = BIN_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] c_acc_max  = '1;

  localparam logic [3:0] c_addr_ctrl      = 4'd0;
  localparam logic [3:0] c_addr_band      = 4'd1;
  localparam logic [3:0] c_addr_status    = 4'd2;
  localparam logic [3:0] c_addr_peak_val  = 4'd3;
  localparam logic [3:0] c_addr_peak_info = 4'd4;
  localparam logic [3:0] c_addr_energy_lo = 4'd5;
  localparam logic [3:0] c_addr_energy_hi = 4'd6;
  localparam logic [3:0] c_addr_frame_cnt = 4'd7;

  state_t             state_q, state_d;
  logic               enable_q, enable_d;
  logic [BIN_W-1:0]   lo_q, lo_d;
  logic [BIN_W-1:0]   hi_q, hi_d;
  logic               done_q, done_d;
  logic               len_err_q, len_err_d;
  logic               ovr_q, ovr_d;
  logic [31:0]        peak_val_q, peak_val_d;
  logic [BIN_W-1:0]   peak_idx_q, peak_idx_d;
  logic [5:0]         peak_exp_q, peak_exp_d;
  logic [ACC_W-1:0]   energy_q, energy_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [31:0]        acc_peak_q, acc_peak_d;
  logic [BIN_W-1:0]   acc_idx_q, acc_idx_d;
  logic [ACC_W-1:0]   acc_energy_q, acc_energy_d;
  logic [31:0]        rddata_q, rddata_d;

  logic               w_bus_wr;
  logic               w_bus_rd;
  logic [BIN_W-1:0]   w_beat_bin;
  logic               w_in_band;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_sum_sat;
  logic [ACC_W-1:0]   w_first_energy;
  logic [31:0]        w_nxt_peak;
  logic [BIN_W-1:0]   w_nxt_idx;
  logic [ACC_W-1:0]   w_nxt_energy;
  logic               w_done_set;
  logic               w_len_err_set;
  logic [31:0]        w_rd_mux;
  logic [31:0]        w_peak_info;
  logic [63:0]        w_energy_ext;
  logic               w_unused;

  assign w_bus_wr = cs & wr;
  assign w_bus_rd = cs & rd & ~wr;

  // A sop beat is always bin 0, even when it restarts a frame in ACCUM.
  assign w_beat_bin     = (state_q == ACCUM && !in_sop) ? bin_q + 1'b1 : '0;
  assign w_in_band      = (w_beat_bin >= lo_q) && (w_beat_bin <= hi_q);
  assign w_sum          = {1'b0, acc_energy_q} + {{(ACC_W-31){1'b0}}, in_data};
  assign w_sum_sat      = w_sum[ACC_W] ? c_acc_max : w_sum[ACC_W-1:0];
  assign w_first_energy = w_in_band ? {{(ACC_W-32){1'b0}}, in_data} : '0;

  always_comb begin
    w_nxt_peak   = acc_peak_q;
    w_nxt_idx    = acc_idx_q;
    w_nxt_energy = acc_energy_q;
    if (w_in_band) begin
      w_nxt_energy = w_sum_sat;
      if (in_data > acc_peak_q) begin
        w_nxt_peak = in_data;
        w_nxt_idx  = w_beat_bin;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    acc_peak_d    = acc_peak_q;
    acc_idx_d     = acc_idx_q;
    acc_energy_d  = acc_energy_q;
    peak_val_d    = peak_val_q;
    peak_idx_d    = peak_idx_q;
    peak_exp_d    = peak_exp_q;
    energy_d      = energy_q;
    frame_cnt_d   = frame_cnt_q;
    w_done_set    = 1'b0;
    w_len_err_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_sop && enable_q) begin
          if (in_eop) begin
            w_len_err_set = 1'b1;
          end else begin
            bin_d        = '0;
            acc_peak_d   = w_in_band ? in_data : '0;
            acc_idx_d    = '0;
            acc_energy_d = w_first_energy;
            state_d      = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else if (in_valid) begin
          if (in_sop) begin
            w_len_err_set = 1'b1;
            if (in_eop) begin
              state_d = IDLE;
            end else begin
              bin_d        = '0;
              acc_peak_d   = w_in_band ? in_data : '0;
              acc_idx_d    = '0;
              acc_energy_d = w_first_energy;
            end
          end else begin
            bin_d        = w_beat_bin;
            acc_peak_d   = w_nxt_peak;
            acc_idx_d    = w_nxt_idx;
            acc_energy_d = w_nxt_energy;
            if (in_eop && w_beat_bin == c_last_bin) begin
              peak_val_d  = w_nxt_peak;
              peak_idx_d  = w_nxt_idx;
              peak_exp_d  = in_exp;
              energy_d    = w_nxt_energy;
              frame_cnt_d = frame_cnt_q + 16'd1;
              w_done_set  = 1'b1;
              state_d     = IDLE;
            end else if (in_eop || w_beat_bin == c_last_bin) begin
              w_len_err_set = 1'b1;
              state_d       = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus writes first, then flag sets, so a set beats a same-cycle W1C.
  always_comb begin
    enable_d  = enable_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    done_d    = done_q;
    len_err_d = len_err_q;
    ovr_d     = ovr_q;

    if (w_bus_wr) begin
      case (addr)
        c_addr_ctrl: enable_d = wrdata[0];
        c_addr_band: begin
          lo_d = wrdata[BIN_W-1:0];
          hi_d = wrdata[16+BIN_W-1:16];
        end
        c_addr_status: begin
          done_d    = done_q    & ~wrdata[0];
          len_err_d = len_err_q & ~wrdata[1];
          ovr_d     = ovr_q     & ~wrdata[2];
        end
        default: ;
      endcase
    end

    if (w_done_set) begin
      done_d = 1'b1;
      if (done_q) ovr_d = 1'b1;
    end
    if (w_len_err_set) len_err_d = 1'b1;
  end

  always_comb begin
    w_peak_info                = '0;
    w_peak_info[BIN_W-1:0]     = peak_idx_q;
    w_peak_info[21:16]         = peak_exp_q;
    w_energy_ext               = '0;
    w_energy_ext[ACC_W-1:0]    = energy_q;

    case (addr)
      c_addr_ctrl:      w_rd_mux = {31'd0, enable_q};
      c_addr_band: begin
        w_rd_mux                 = '0;
        w_rd_mux[BIN_W-1:0]      = lo_q;
        w_rd_mux[16+BIN_W-1:16]  = hi_q;
      end
      c_addr_status:    w_rd_mux = {29'd0, ovr_q, len_err_q, done_q};
      c_addr_peak_val:  w_rd_mux = peak_val_q;
      c_addr_peak_info: w_rd_mux = w_peak_info;
      c_addr_energy_lo: w_rd_mux = w_energy_ext[31:0];
      c_addr_energy_hi: w_rd_mux = w_energy_ext[63:32];
      c_addr_frame_cnt: w_rd_mux = {16'd0, frame_cnt_q};
      default:          w_rd_mux = '0;
    endcase

    rddata_d = w_bus_rd ? w_rd_mux : rddata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
      ovr_q        <= 1'b0;
      peak_val_q   <= '0;
      peak_idx_q   <= '0;
      peak_exp_q   <= '0;
      energy_q     <= '0;
      frame_cnt_q  <= '0;
      bin_q        <= '0;
      acc_peak_q   <= '0;
      acc_idx_q    <= '0;
      acc_energy_q <= '0;
      rddata_q     <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      done_q       <= done_d;
      len_err_q    <= len_err_d;
      ovr_q        <= ovr_d;
      peak_val_q   <= peak_val_d;
      peak_idx_q   <= peak_idx_d;
      peak_exp_q   <= peak_exp_d;
      energy_q     <= energy_d;
      frame_cnt_q  <= frame_cnt_d;
      bin_q        <= bin_d;
      acc_peak_q   <= acc_peak_d;
      acc_idx_q    <= acc_idx_d;
      acc_energy_q <= acc_energy_d;
      rddata_q     <= rddata_d;
    end
  end

  assign rddata = rddata_q;
  assign irq    = done_q;

  assign w_unused = ^wrdata;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_peak_scan.sv
// ============================================================================
// tb_spectrum_peak_scan : register-level checks of frame scan results and flags
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spectrum_peak_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_exp = '0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] rddata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fdata [256];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t sb_q [$];

  spectrum_peak_scan #(
    .FRAME_LEN(256),
    .BIN_W    (8),
    .ACC_W    (33)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_sop  (in_sop),
    .in_eop  (in_eop),
    .in_data (in_data),
    .in_exp  (in_exp),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wrdata  (wrdata),
    .rddata  (rddata),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wrdata = d;
    tick();
    cs = 1'b0; wr = 1'b0; wrdata = '0;
  endtask

  // Expected value queued as the read is issued, checked when rddata lands.
  task automatic read_reg(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_vec_t v;
    v.addr = a; v.exp = exp; v.name = name;
    sb_q.push_back(v);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    v = sb_q.pop_front();
    chk(v.name, rddata, v.exp);
  endtask

  task automatic check_regs(input logic [31:0] st, input logic [31:0] pv,
                            input logic [7:0] idx, input logic [5:0] e,
                            input logic [63:0] en, input logic [15:0] fc);
    rd_vec_t tbl [6];
    tbl[0] = '{addr: 4'd2, exp: st,                      name: "STATUS"};
    tbl[1] = '{addr: 4'd3, exp: pv,                      name: "PEAK_VAL"};
    tbl[2] = '{addr: 4'd4, exp: {10'd0, e, 8'd0, idx},   name: "PEAK_INFO"};
    tbl[3] = '{addr: 4'd5, exp: en[31:0],                name: "ENERGY_LO"};
    tbl[4] = '{addr: 4'd6, exp: en[63:32],               name: "ENERGY_HI"};
    tbl[5] = '{addr: 4'd7, exp: {16'd0, fc},             name: "FRAME_CNT"};
    for (int i = 0; i < 6; i++) read_reg(tbl[i].addr, tbl[i].exp, tbl[i].name);
  endtask

  task automatic check_all_zero(input string tag);
    rd_vec_t tbl [9];
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 4'(i), exp: 32'd0, name: $sformatf("%s_reg%0d", tag, i)};
    tbl[8] = '{addr: 4'd12, exp: 32'd0, name: $sformatf("%s_reg12", tag)};
    for (int i = 0; i < 9; i++) read_reg(tbl[i].addr, tbl[i].exp, tbl[i].name);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  // Optional random stall cycles carry junk sop/eop/data with valid low.
  task automatic beat(input logic [31:0] d, input bit sop, input bit eop,
                      input logic [5:0] e, input bit gaps, input bit w1c);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_sop   = 1'($urandom_range(0, 1));
        in_eop   = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        tick();
      end
    end
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d; in_exp = e;
    if (w1c && eop) begin
      cs = 1'b1; wr = 1'b1; addr = 4'd2; wrdata = 32'h7;
    end
    tick();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    cs = 1'b0; wr = 1'b0; wrdata = '0;
  endtask

  task automatic send_frame(input int first, input int last, input int eop_at,
                            input logic [5:0] e, input bit gaps, input bit w1c);
    for (int b = first; b <= last; b++) beat(fdata[b], b == 0, b == eop_at, e, gaps, w1c);
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < 256; b++) fdata[b] = 32'(b);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Full-band ramp, back-to-back beats.
    write_reg(4'd0, 32'h1);
    write_reg(4'd1, 32'h00FF_0000);
    read_reg(4'd0, 32'h1, "CTRL");
    read_reg(4'd1, 32'h00FF_0000, "BAND");
    fill_ramp();
    send_frame(0, 255, 255, 6'h3B, 1'b0, 1'b0);
    check_regs(32'h1, 32'd255, 8'd255, 6'h3B, 64'd32640, 16'd1);
    chk("irq_after_frame", {31'd0, irq}, 32'd1);
    write_reg(4'd2, 32'h1);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Narrow band with stalls; tie at 1000 keeps the earlier bin.
    write_reg(4'd1, (32'd20 << 16) | 32'd10);
    for (int b = 0; b < 256; b++) fdata[b] = 32'd5;
    fdata[12] = 32'd1000;
    fdata[15] = 32'd1000;
    send_frame(0, 255, 255, 6'h05, 1'b1, 1'b0);
    check_regs(32'h1, 32'd1000, 8'd12, 6'h05, 64'd2045, 16'd2);

    // Saturating energy with all-ones data.
    write_reg(4'd2, 32'h7);
    write_reg(4'd1, 32'h00FF_0000);
    for (int b = 0; b < 256; b++) fdata[b] = 32'hFFFF_FFFF;
    send_frame(0, 255, 255, 6'h01, 1'b0, 1'b0);
    check_regs(32'h1, 32'hFFFF_FFFF, 8'd0, 6'h01, 64'h1_FFFF_FFFF, 16'd3);

    // Early eop: discarded, results untouched.
    write_reg(4'd2, 32'h7);
    fill_ramp();
    send_frame(0, 100, 100, 6'h09, 1'b0, 1'b0);
    check_regs(32'h2, 32'hFFFF_FFFF, 8'd0, 6'h01, 64'h1_FFFF_FFFF, 16'd3);

    // Missing eop at the last bin.
    write_reg(4'd2, 32'h7);
    send_frame(0, 255, -1, 6'h09, 1'b0, 1'b0);
    read_reg(4'd2, 32'h2, "STATUS_no_eop");

    // sop and eop on the same beat.
    write_reg(4'd2, 32'h7);
    beat(32'd77, 1'b1, 1'b1, 6'h09, 1'b0, 1'b0);
    read_reg(4'd2, 32'h2, "STATUS_sop_eop");

    // sop mid-frame restarts; the restarted frame closes normally.
    write_reg(4'd2, 32'h7);
    for (int b = 0; b < 40; b++) fdata[b] = 32'hDEAD_0000 | 32'(b);
    send_frame(0, 39, -1, 6'h09, 1'b0, 1'b0);
    fill_ramp();
    send_frame(0, 255, 255, 6'h12, 1'b0, 1'b0);
    check_regs(32'h3, 32'd255, 8'd255, 6'h12, 64'd32640, 16'd4);

    // Overrun, then W1C colliding with the third eop.
    write_reg(4'd2, 32'h7);
    send_frame(0, 255, 255, 6'h12, 1'b0, 1'b0);
    read_reg(4'd2, 32'h1, "STATUS_first_done");
    send_frame(0, 255, 255, 6'h12, 1'b0, 1'b0);
    read_reg(4'd2, 32'h5, "STATUS_ovr");
    send_frame(0, 255, 255, 6'h12, 1'b0, 1'b1);
    read_reg(4'd2, 32'h5, "STATUS_set_beats_w1c");
    read_reg(4'd7, 32'd7, "FRAME_CNT_ovr");
    write_reg(4'd2, 32'h7);
    read_reg(4'd2, 32'h0, "STATUS_cleared");

    // Disabling mid-frame aborts silently.
    send_frame(0, 29, -1, 6'h12, 1'b0, 1'b0);
    write_reg(4'd0, 32'h0);
    send_frame(30, 255, 255, 6'h12, 1'b0, 1'b0);
    read_reg(4'd2, 32'h0, "STATUS_disabled");
    read_reg(4'd7, 32'd7, "FRAME_CNT_disabled");

    // Reset mid-frame, then a full frame with enable still cleared.
    write_reg(4'd0, 32'h1);
    send_frame(0, 49, -1, 6'h12, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_frame(0, 255, 255, 6'h12, 1'b0, 1'b0);
    check_all_zero("post_rst");

    write_reg(4'd0, 32'h1);
    write_reg(4'd1, 32'h00FF_0000);
    send_frame(0, 255, 255, 6'h2C, 1'b1, 1'b0);
    check_regs(32'h1, 32'd255, 8'd255, 6'h2C, 64'd32640, 16'd1);

    // Empty band (lo > hi).
    write_reg(4'd2, 32'h1);
    write_reg(4'd1, (32'd100 << 16) | 32'd200);
    send_frame(0, 255, 255, 6'h21, 1'b0, 1'b0);
    check_regs(32'h1, 32'd0, 8'd0, 6'h21, 64'd0, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
